rename_alloc: RTL and testbench
===============================

RENAME_ALLOC -- requirements
Module: rename_alloc

Interface
REQ-001 Parameter CKPT_DEPTH, default 4, number of branch checkpoints (power of two).
REQ-002 Parameter FL_RESET_PTR, default 32, free-list read-pointer value after reset.
REQ-003 clk  in  1  rising-edge clock; sole clock.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 in_valid/in_ready  in/out  1/1  decode-side handshake.
REQ-006 in_rd  in  5  architectural destination.
REQ-007 in_has_rd  in  1  instruction writes rd.
REQ-008 in_is_branch  in  1  instruction needs a checkpoint.
REQ-009 out_valid/out_ready  out/in  1/1  dispatch-side handshake.
REQ-010 out_pd  out  7  allocated physical destination; 0 when none allocated.
REQ-011 out_br_tag  out  log2(CKPT_DEPTH)  checkpoint tag; valid only with a branch.
REQ-012 fl_read_en  out  1  pop request to the free list.
REQ-013 fl_pd_new  in  7  free-list head entry.
REQ-014 fl_empty  in  1  free list has no entries.
REQ-015 fl_mispredict  out  1  one-cycle free-list rollback strobe.
REQ-016 fl_re_ptr  out  7  rollback read pointer, valid with fl_mispredict.
REQ-017 br_resolve_valid, br_mispredict, br_tag  in  1,1,log2(CKPT_DEPTH)  branch resolution.

Function
REQ-018 needs_alloc = in_has_rd and in_rd != 0; accept = in_valid and in_ready.
REQ-019 in_ready = (out_valid=0 or out_ready=1) and state=NORMAL and not (needs_alloc and fl_empty) and not (in_is_branch and ckpt_full) and not (br_resolve_valid and br_mispredict).
REQ-020 fl_read_en = accept and needs_alloc, combinational, same cycle; never asserted while fl_empty.
REQ-021 On accept, output register loads out_pd = fl_pd_new if needs_alloc else 0; out_valid=1 next cycle; latency one cycle.
REQ-022 Output register holds its contents while out_valid=1 and out_ready=0; it clears when out_ready=1 and no accept occurs.
REQ-023 Shadow pointer sptr (7 bit) mirrors the free-list read pointer: +1 per fl_read_en, wrap 127->1 (never 0).
REQ-024 Checkpoints form a circular queue (head, tail, count); ckpt_full = (count == CKPT_DEPTH).
REQ-025 Branch accept writes ckpt[tail].ptr = post-allocation sptr, sets entry live, out_br_tag = tail, tail+1, count+1.
REQ-026 Correct resolution (br_mispredict=0) marks ckpt[br_tag] resolved; head advances one entry per cycle past resolved entries, count decrementing.
REQ-027 Mispredict: fl_mispredict=1 and fl_re_ptr=ckpt[br_tag].ptr in the same cycle (combinational from inputs); next cycle sptr=that ptr, tail=br_tag+1, count recomputed, younger entries dropped, out_valid=0.
REQ-028 FSM NORMAL->RECOVER on mispredict; RECOVER->NORMAL after exactly one cycle; in_ready=0 in RECOVER.
REQ-029 Mispredict has priority over accept, correct resolution, and head advance in the same cycle.
REQ-030 Resolution of a non-live tag is ignored (no strobe, no state change).

Reset
REQ-031 On reset low: sptr=FL_RESET_PTR, head=tail=count=0, all entries non-live, state=NORMAL, out_valid=0, out_pd=0, out_br_tag=0; fl_read_en=fl_mispredict=0 while reset is low.
REQ-032 Reset mid-operation discards all in-flight and checkpoint state without further strobes.

Structure
REQ-033 Shared package rename_pkg holds PREG_W=7, ARCH_W=5, CKPT_DEPTH, the tag typedef, the state enum, and the checkpoint-entry struct (ptr, live, resolved).
REQ-034 One sub-module ckpt_queue (circular queue of entries with alloc, resolve, truncate ports); all remaining logic lives in rename_alloc.

Verification
REQ-035 After reset, rd=5 accepted with fl_pd_new=32 -> fl_read_en=1 that cycle, next cycle out_valid=1 and out_pd=32, sptr=33.
REQ-036 rd=0 with in_has_rd=1 -> fl_read_en=0, out_pd=0, sptr unchanged.
REQ-037 fl_empty=1 with needs_alloc -> in_ready=0; an rd-less instruction is still accepted.
REQ-038 Four branches accepted (tags 0..3) -> in_ready=0 for a fifth branch; correct resolve of tag 0 -> fifth branch accepted with tag 0.
REQ-039 Branch at sptr=40, then three allocations, then mispredict tag -> fl_mispredict=1 with fl_re_ptr=40; next cycle sptr=40, out_valid=0; one RECOVER cycle.
REQ-040 sptr at 127 plus one allocation -> sptr=1; a mispredict and an accept in the same cycle -> mispredict only, no fl_read_en.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared types and constants for the register-rename allocation stage.
package rename_pkg;

  localparam int unsigned PREG_W     = 7;
  localparam int unsigned ARCH_W     = 5;
  localparam int unsigned CKPT_DEPTH = 4;
  localparam int unsigned TAG_W      = $clog2(CKPT_DEPTH);

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [PREG_W-1:0] preg_t;

  typedef enum logic [0:0] {
    ST_NORMAL  = 1'b0,
    ST_RECOVER = 1'b1
  } state_e;

  // One branch checkpoint: free-list read pointer to restore, plus lifecycle bits.
  typedef struct packed {
    preg_t ptr;
    logic  live;
    logic  resolved;
  } ckpt_entry_t;

  // Free-list pointer increment; physical register 0 is never handed out.
  function automatic preg_t preg_inc(input preg_t p);
    return (p == '1) ? preg_t'(1) : preg_t'(p + preg_t'(1));
  endfunction

endpackage

// File: rtl/ckpt_queue.sv
// Circular queue of branch checkpoints with allocate, resolve and truncate.
module ckpt_queue
  import rename_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned TW    = $clog2(DEPTH),
  localparam int unsigned CW    = TW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          alloc_i,
  input  preg_t         alloc_ptr_i,
  output logic [TW-1:0] tail_o,
  output logic          full_o,
  input  logic          resolve_i,
  input  logic [TW-1:0] resolve_tag_i,
  input  logic          trunc_i,
  input  logic [TW-1:0] trunc_tag_i,
  input  logic [TW-1:0] query_tag_i,
  output ckpt_entry_t   query_c_o
);

  ckpt_entry_t   entries_q [DEPTH];
  ckpt_entry_t   entries_d [DEPTH];
  logic [TW-1:0] head_q, head_d;
  logic [TW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          retire_c;
  logic [TW-1:0] trunc_pos_c;

  assign tail_o    = tail_q;
  assign full_o    = full_q;
  assign query_c_o = entries_q[query_tag_i];

  // Next-state: truncation wins; otherwise resolve, retire the head, and append.
  always_comb begin
    entries_d   = entries_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    retire_c    = 1'b0;
    trunc_pos_c = trunc_tag_i - head_q;
    if (trunc_i) begin
      // Entries positioned after the mispredicted branch (relative to head) are squashed.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (TW'(TW'(i) - head_q) > trunc_pos_c) begin
          entries_d[i].live     = 1'b0;
          entries_d[i].resolved = 1'b0;
        end
      end
      entries_d[trunc_tag_i].resolved = 1'b1;
      tail_d  = trunc_tag_i + TW'(1);
      count_d = CW'(trunc_pos_c) + CW'(1);
    end else begin
      retire_c = (count_q != '0) && entries_q[head_q].live && entries_q[head_q].resolved;
      if (resolve_i) begin
        entries_d[resolve_tag_i].resolved = 1'b1;
      end
      if (retire_c) begin
        entries_d[head_q].live     = 1'b0;
        entries_d[head_q].resolved = 1'b0;
        head_d = head_q + TW'(1);
      end
      if (alloc_i) begin
        entries_d[tail_q].ptr      = alloc_ptr_i;
        entries_d[tail_q].live     = 1'b1;
        entries_d[tail_q].resolved = 1'b0;
        tail_d = tail_q + TW'(1);
      end
      count_d = count_q + CW'(alloc_i) - CW'(retire_c);
    end
    full_d = (count_d == CW'(DEPTH));
  end

  // Queue state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      full_q    <= full_d;
    end
  end

endmodule

// File: rtl/rename_alloc.sv
// Rename allocation stage: pops physical destinations from the free list,
// checkpoints the free-list pointer at branches, and rolls back on mispredict.
module rename_alloc
  import rename_pkg::*;
#(
  parameter  int unsigned CKPT_DEPTH   = rename_pkg::CKPT_DEPTH,
  parameter  int unsigned FL_RESET_PTR = 32,
  localparam int unsigned BR_TAG_W     = $clog2(CKPT_DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [ARCH_W-1:0]   in_rd_i,
  input  logic                in_has_rd_i,
  input  logic                in_is_branch_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [PREG_W-1:0]   out_pd_o,
  output logic [BR_TAG_W-1:0] out_br_tag_o,
  output logic                fl_read_en_o,
  input  logic [PREG_W-1:0]   fl_pd_new_i,
  input  logic                fl_empty_i,
  output logic                fl_mispredict_o,
  output logic [PREG_W-1:0]   fl_re_ptr_o,
  input  logic                br_resolve_valid_i,
  input  logic                br_mispredict_i,
  input  logic [BR_TAG_W-1:0] br_tag_i
);

  state_e                state_q, state_d;
  preg_t                 sptr_q, sptr_d;
  logic                  out_valid_q, out_valid_d;
  preg_t                 out_pd_q, out_pd_d;
  logic [BR_TAG_W-1:0]   out_br_tag_q, out_br_tag_d;

  logic                  needs_alloc_c;
  logic                  accept_c;
  logic                  branch_alloc_c;
  logic                  tag_ok_c;
  logic                  misp_c;
  logic                  resolve_c;
  preg_t                 sptr_inc_c;
  preg_t                 ckpt_ptr_c;
  logic [BR_TAG_W-1:0]   ckpt_tail;
  logic                  ckpt_full;
  ckpt_entry_t           ckpt_query_c;

  // Only live, still-unresolved checkpoints react to a resolution.
  assign needs_alloc_c = in_has_rd_i && (in_rd_i != '0);
  assign tag_ok_c      = ckpt_query_c.live && !ckpt_query_c.resolved;
  assign misp_c        = rst_ni && br_resolve_valid_i && br_mispredict_i && tag_ok_c;
  assign resolve_c     = rst_ni && br_resolve_valid_i && !br_mispredict_i && tag_ok_c;

  assign in_ready_o = rst_ni
                   && (!out_valid_q || out_ready_i)
                   && (state_q == ST_NORMAL)
                   && !(needs_alloc_c && fl_empty_i)
                   && !(in_is_branch_i && ckpt_full)
                   && !(br_resolve_valid_i && br_mispredict_i);

  assign accept_c       = in_valid_i && in_ready_o;
  assign fl_read_en_o   = accept_c && needs_alloc_c;
  assign branch_alloc_c = accept_c && in_is_branch_i;
  assign sptr_inc_c     = preg_inc(sptr_q);
  assign ckpt_ptr_c     = fl_read_en_o ? sptr_inc_c : sptr_q;

  assign fl_mispredict_o = misp_c;
  assign fl_re_ptr_o     = misp_c ? ckpt_query_c.ptr : '0;

  assign out_valid_o  = out_valid_q;
  assign out_pd_o     = out_pd_q;
  assign out_br_tag_o = out_br_tag_q;

  ckpt_queue #(
    .DEPTH (CKPT_DEPTH)
  ) u_ckpt_queue (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .alloc_i       (branch_alloc_c),
    .alloc_ptr_i   (ckpt_ptr_c),
    .tail_o        (ckpt_tail),
    .full_o        (ckpt_full),
    .resolve_i     (resolve_c),
    .resolve_tag_i (br_tag_i),
    .trunc_i       (misp_c),
    .trunc_tag_i   (br_tag_i),
    .query_tag_i   (br_tag_i),
    .query_c_o     (ckpt_query_c)
  );

  // Recovery FSM: one dead cycle after any rollback.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL:  if (misp_c) state_d = ST_RECOVER;
      ST_RECOVER: state_d = ST_NORMAL;
      default:    state_d = ST_NORMAL;
    endcase
  end

  // Shadow pointer and output register next-state; rollback overrides everything.
  always_comb begin
    sptr_d       = sptr_q;
    out_valid_d  = out_valid_q;
    out_pd_d     = out_pd_q;
    out_br_tag_d = out_br_tag_q;
    if (misp_c) begin
      sptr_d       = ckpt_query_c.ptr;
      out_valid_d  = 1'b0;
      out_pd_d     = '0;
      out_br_tag_d = '0;
    end else begin
      if (fl_read_en_o) begin
        sptr_d = sptr_inc_c;
      end
      if (accept_c) begin
        out_valid_d  = 1'b1;
        out_pd_d     = needs_alloc_c ? fl_pd_new_i : '0;
        out_br_tag_d = in_is_branch_i ? ckpt_tail : '0;
      end else if (out_ready_i) begin
        out_valid_d  = 1'b0;
        out_pd_d     = '0;
        out_br_tag_d = '0;
      end
    end
  end

  // State, shadow pointer and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_NORMAL;
      sptr_q       <= PREG_W'(FL_RESET_PTR);
      out_valid_q  <= 1'b0;
      out_pd_q     <= '0;
      out_br_tag_q <= '0;
    end else begin
      state_q      <= state_d;
      sptr_q       <= sptr_d;
      out_valid_q  <= out_valid_d;
      out_pd_q     <= out_pd_d;
      out_br_tag_q <= out_br_tag_d;
    end
  end

endmodule

// File: tb/tb_rename_alloc.sv
// Self-checking bench for rename_alloc with an output scoreboard.
module tb_rename_alloc;

  typedef struct packed {
    logic [6:0] pd;
    logic [1:0] tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_rd = '0;
  logic       in_has_rd = 1'b0;
  logic       in_is_branch = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [6:0] out_pd;
  logic [1:0] out_br_tag;
  logic       fl_read_en;
  logic [6:0] fl_pd_new = '0;
  logic       fl_empty = 1'b0;
  logic       fl_mispredict;
  logic [6:0] fl_re_ptr;
  logic       br_resolve_valid = 1'b0;
  logic       br_mispredict = 1'b0;
  logic [1:0] br_tag = '0;

  exp_t       sb[$];
  exp_t       mon_e;
  int         pass_cnt = 0;
  int         total_cnt = 0;
  logic [6:0] m_sptr = 7'd32;

  always #5 clk = ~clk;

  rename_alloc #(
    .CKPT_DEPTH   (4),
    .FL_RESET_PTR (32)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .in_valid_i         (in_valid),
    .in_ready_o         (in_ready),
    .in_rd_i            (in_rd),
    .in_has_rd_i        (in_has_rd),
    .in_is_branch_i     (in_is_branch),
    .out_valid_o        (out_valid),
    .out_ready_i        (out_ready),
    .out_pd_o           (out_pd),
    .out_br_tag_o       (out_br_tag),
    .fl_read_en_o       (fl_read_en),
    .fl_pd_new_i        (fl_pd_new),
    .fl_empty_i         (fl_empty),
    .fl_mispredict_o    (fl_mispredict),
    .fl_re_ptr_o        (fl_re_ptr),
    .br_resolve_valid_i (br_resolve_valid),
    .br_mispredict_i    (br_mispredict),
    .br_tag_i           (br_tag)
  );

  // Scoreboard: every completed output handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      total_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: got pd=%0d tag=%0d, required no output", out_pd, out_br_tag);
      end else begin
        mon_e = sb.pop_front();
        if (out_pd !== mon_e.pd || out_br_tag !== mon_e.tag)
          $display("FAIL sb_out: got pd=%0d tag=%0d, required pd=%0d tag=%0d",
                   out_pd, out_br_tag, mon_e.pd, mon_e.tag);
        else pass_cnt++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1);
  end

  task automatic set_idle();
    in_valid = 1'b0; in_rd = '0; in_has_rd = 1'b0; in_is_branch = 1'b0;
    fl_pd_new = '0; fl_empty = 1'b0; out_ready = 1'b1;
    br_resolve_valid = 1'b0; br_mispredict = 1'b0; br_tag = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [6:0] pd, input logic [1:0] tag);
    exp_t e;
    e.pd = pd;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic model_alloc();
    m_sptr = (m_sptr == 7'd127) ? 7'd1 : m_sptr + 7'd1;
  endtask

  task automatic drive_instr(input logic [4:0] rd, input logic has, input logic br,
                             input logic [6:0] pd, input logic empty);
    next_cycle();
    set_idle();
    in_valid = 1'b1; in_rd = rd; in_has_rd = has; in_is_branch = br;
    fl_pd_new = pd; fl_empty = empty;
    @(negedge clk);
  endtask

  task automatic drive_resolve(input logic misp, input logic [1:0] tag);
    next_cycle();
    set_idle();
    br_resolve_valid = 1'b1; br_mispredict = misp; br_tag = tag;
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      next_cycle();
      set_idle();
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    next_cycle();
    set_idle();
    rst_n = 1'b0;
    sb.delete();
    m_sptr = 7'd32;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    next_cycle();
    rst_n = 1'b0;
    set_idle();
    in_valid = 1'b1; in_rd = 5'd5; in_has_rd = 1'b1; fl_pd_new = 7'd32;
    br_resolve_valid = 1'b1; br_mispredict = 1'b1; br_tag = 2'd0;
    @(negedge clk);
    total_cnt++; if (fl_read_en !== 1'b0) $display("FAIL rst_read_en: got %0d required 0", fl_read_en); else pass_cnt++;
    total_cnt++; if (fl_mispredict !== 1'b0) $display("FAIL rst_mispredict: got %0d required 0", fl_mispredict); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0d required 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_pd !== 7'd0) $display("FAIL rst_out_pd: got %0d required 0", out_pd); else pass_cnt++;
    total_cnt++; if (out_br_tag !== 2'd0) $display("FAIL rst_out_tag: got %0d required 0", out_br_tag); else pass_cnt++;
    total_cnt++; if (dut.sptr_q !== 7'd32) $display("FAIL rst_sptr: got %0d required 32", dut.sptr_q); else pass_cnt++;
    next_cycle();
    set_idle();
    rst_n = 1'b1;
    sb.delete();
    m_sptr = 7'd32;
    @(negedge clk);
  endtask

  task automatic test_alloc();
    do_reset();
    drive_instr(5'd5, 1'b1, 1'b0, 7'd32, 1'b0);
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL alloc_ready: got %0d required 1", in_ready); else pass_cnt++;
    total_cnt++; if (fl_read_en !== 1'b1) $display("FAIL alloc_read_en: got %0d required 1", fl_read_en); else pass_cnt++;
    push_exp(7'd32, 2'd0);
    model_alloc();
    drive_instr(5'd0, 1'b1, 1'b0, 7'd50, 1'b0);
    total_cnt++; if (out_valid !== 1'b1 || out_pd !== 7'd32) $display("FAIL alloc_latency: got valid=%0d pd=%0d required valid=1 pd=32", out_valid, out_pd); else pass_cnt++;
    total_cnt++; if (dut.sptr_q !== m_sptr) $display("FAIL alloc_sptr: got %0d required %0d", dut.sptr_q, m_sptr); else pass_cnt++;
    total_cnt++; if (fl_read_en !== 1'b0) $display("FAIL rd0_read_en: got %0d required 0", fl_read_en); else pass_cnt++;
    push_exp(7'd0, 2'd0);
    drive_instr(5'd7, 1'b0, 1'b0, 7'd51, 1'b0);
    total_cnt++; if (fl_read_en !== 1'b0) $display("FAIL nord_read_en: got %0d required 0", fl_read_en); else pass_cnt++;
    push_exp(7'd0, 2'd0);
    idle_cycles(2);
    total_cnt++; if (dut.sptr_q !== m_sptr) $display("FAIL rd0_sptr: got %0d required %0d", dut.sptr_q, m_sptr); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL alloc_drain: got out_valid=%0d required 0", out_valid); else pass_cnt++;
    total_cnt++; if (sb.size() != 0) $display("FAIL alloc_pending: got %0d pending required 0", sb.size()); else pass_cnt++;
  endtask

  task automatic test_fl_empty();
    do_reset();
    drive_instr(5'd3, 1'b1, 1'b0, 7'd40, 1'b1);
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL empty_ready: got %0d required 0", in_ready); else pass_cnt++;
    total_cnt++; if (fl_read_en !== 1'b0) $display("FAIL empty_read_en: got %0d required 0", fl_read_en); else pass_cnt++;
    drive_instr(5'd3, 1'b0, 1'b0, 7'd40, 1'b1);
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL empty_nord_ready: got %0d required 1", in_ready); else pass_cnt++;
    push_exp(7'd0, 2'd0);
    idle_cycles(2);
    total_cnt++; if (dut.sptr_q !== 7'd32) $display("FAIL empty_sptr: got %0d required 32", dut.sptr_q); else pass_cnt++;
    total_cnt++; if (sb.size() != 0) $display("FAIL empty_pending: got %0d pending required 0", sb.size()); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    drive_instr(5'd9, 1'b1, 1'b0, 7'd60, 1'b0);
    push_exp(7'd60, 2'd0);
    model_alloc();
    repeat (2) begin
      next_cycle();
      set_idle();
      out_ready = 1'b0; in_valid = 1'b1; in_rd = 5'd10; in_has_rd = 1'b1; fl_pd_new = 7'd61;
      @(negedge clk);
      total_cnt++; if (in_ready !== 1'b0 || fl_read_en !== 1'b0) $display("FAIL bp_ready: got ready=%0d read_en=%0d required 0/0", in_ready, fl_read_en); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b1 || out_pd !== 7'd60) $display("FAIL bp_hold: got valid=%0d pd=%0d required 1/60", out_valid, out_pd); else pass_cnt++;
    end
    idle_cycles(2);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_clear: got out_valid=%0d required 0", out_valid); else pass_cnt++;
    total_cnt++; if (dut.sptr_q !== m_sptr) $display("FAIL bp_sptr: got %0d required %0d", dut.sptr_q, m_sptr); else pass_cnt++;
    total_cnt++; if (sb.size() != 0) $display("FAIL bp_pending: got %0d pending required 0", sb.size()); else pass_cnt++;
  endtask

  task automatic test_ckpt_full();
    logic got;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_instr(5'd0, 1'b0, 1'b1, 7'd0, 1'b0);
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL br_ready_%0d: got %0d required 1", i, in_ready); else pass_cnt++;
      push_exp(7'd0, 2'(i));
    end
    drive_instr(5'd0, 1'b0, 1'b1, 7'd0, 1'b0);
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL br_full: got %0d required 0", in_ready); else pass_cnt++;
    drive_resolve(1'b0, 2'd0);
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      drive_instr(5'd0, 1'b0, 1'b1, 7'd0, 1'b0);
      if (in_ready === 1'b1) begin
        got = 1'b1;
        push_exp(7'd0, 2'd0);
      end
    end
    total_cnt++; if (got !== 1'b1) $display("FAIL br_after_resolve: got ready=%0d within 4 cycles required 1", got); else pass_cnt++;
    idle_cycles(2);
    total_cnt++; if (sb.size() != 0) $display("FAIL br_pending: got %0d pending required 0", sb.size()); else pass_cnt++;
  endtask

  task automatic test_mispredict();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive_instr(5'(i + 1), 1'b1, 1'b0, 7'(100 + i), 1'b0);
      push_exp(7'(100 + i), 2'd0);
      model_alloc();
    end
    drive_instr(5'd0, 1'b0, 1'b1, 7'd0, 1'b0);
    total_cnt++; if (dut.sptr_q !== 7'd40) $display("FAIL mp_sptr_at_branch: got %0d required 40", dut.sptr_q); else pass_cnt++;
    push_exp(7'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      drive_instr(5'(10 + i), 1'b1, 1'b0, 7'(110 + i), 1'b0);
      push_exp(7'(110 + i), 2'd0);
      model_alloc();
    end
    drive_resolve(1'b1, 2'd2);
    total_cnt++; if (fl_mispredict !== 1'b0) $display("FAIL mp_dead_tag: got %0d required 0", fl_mispredict); else pass_cnt++;
    next_cycle();
    set_idle();
    br_resolve_valid = 1'b1; br_mispredict = 1'b1; br_tag = 2'd0;
    in_valid = 1'b1; in_rd = 5'd4; in_has_rd = 1'b1; fl_pd_new = 7'd90;
    @(negedge clk);
    total_cnt++; if (fl_mispredict !== 1'b1 || fl_re_ptr !== 7'd40) $display("FAIL mp_strobe: got strobe=%0d ptr=%0d required 1/40", fl_mispredict, fl_re_ptr); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0 || fl_read_en !== 1'b0) $display("FAIL mp_priority: got ready=%0d read_en=%0d required 0/0", in_ready, fl_read_en); else pass_cnt++;
    m_sptr = 7'd40;
    next_cycle();
    set_idle();
    in_valid = 1'b1; in_rd = 5'd4; in_has_rd = 1'b1; fl_pd_new = 7'd90;
    @(negedge clk);
    total_cnt++; if (dut.sptr_q !== 7'd40) $display("FAIL mp_sptr_restore: got %0d required 40", dut.sptr_q); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL mp_out_flush: got %0d required 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL mp_recover_ready: got %0d required 0", in_ready); else pass_cnt++;
    drive_instr(5'd4, 1'b1, 1'b1, 7'd90, 1'b0);
    total_cnt++; if (in_ready !== 1'b1 || fl_read_en !== 1'b1) $display("FAIL mp_resume: got ready=%0d read_en=%0d required 1/1", in_ready, fl_read_en); else pass_cnt++;
    push_exp(7'd90, 2'd1);
    model_alloc();
    idle_cycles(2);
    total_cnt++; if (dut.sptr_q !== m_sptr) $display("FAIL mp_sptr_after: got %0d required %0d", dut.sptr_q, m_sptr); else pass_cnt++;
    total_cnt++; if (sb.size() != 0) $display("FAIL mp_pending: got %0d pending required 0", sb.size()); else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 95; i++) begin
      drive_instr(5'd1, 1'b1, 1'b0, 7'(i), 1'b0);
      push_exp(7'(i), 2'd0);
      model_alloc();
    end
    drive_instr(5'd2, 1'b1, 1'b0, 7'd5, 1'b0);
    total_cnt++; if (dut.sptr_q !== 7'd127) $display("FAIL wrap_at_top: got %0d required 127", dut.sptr_q); else pass_cnt++;
    total_cnt++; if (fl_read_en !== 1'b1) $display("FAIL wrap_read_en: got %0d required 1", fl_read_en); else pass_cnt++;
    push_exp(7'd5, 2'd0);
    model_alloc();
    idle_cycles(1);
    total_cnt++; if (dut.sptr_q !== 7'd1) $display("FAIL wrap_to_one: got %0d required 1", dut.sptr_q); else pass_cnt++;
    idle_cycles(1);
    total_cnt++; if (sb.size() != 0) $display("FAIL wrap_pending: got %0d pending required 0", sb.size()); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_instr(5'd0, 1'b0, 1'b1, 7'd0, 1'b0);
    push_exp(7'd0, 2'd0);
    drive_instr(5'd6, 1'b1, 1'b0, 7'd70, 1'b0);
    next_cycle();
    set_idle();
    in_valid = 1'b1; in_rd = 5'd6; in_has_rd = 1'b1; fl_pd_new = 7'd71;
    #2 rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0 || fl_read_en !== 1'b0) $display("FAIL mid_rst_out: got valid=%0d read_en=%0d required 0/0", out_valid, fl_read_en); else pass_cnt++;
    total_cnt++; if (dut.sptr_q !== 7'd32) $display("FAIL mid_rst_sptr: got %0d required 32", dut.sptr_q); else pass_cnt++;
    next_cycle();
    set_idle();
    rst_n = 1'b1;
    @(negedge clk);
    drive_resolve(1'b1, 2'd0);
    total_cnt++; if (fl_mispredict !== 1'b0) $display("FAIL mid_rst_ckpt: got %0d required 0", fl_mispredict); else pass_cnt++;
    idle_cycles(1);
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL mid_rst_ready: got %0d required 1", in_ready); else pass_cnt++;
  endtask

  initial begin
    set_idle();
    test_reset();
    test_alloc();
    test_fl_empty();
    test_backpressure();
    test_ckpt_full();
    test_mispredict();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
